// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch / display slice.
//   state_e     : stopwatch FSM state encoding (STOP=0, RUN=1, CLEAR=2)
//   CountW      : width of the count bus that feeds the display controller
//   step_t      : result of one count step (next value plus wrap flag)
//   count_step(): up/down modulo step bounded by a maximum value
package stopwatch_ctrl_pkg;

  localparam int unsigned CountW = 11;

  typedef enum logic [1:0] {
    StStop  = 2'd0,
    StRun   = 2'd1,
    StClear = 2'd2
  } state_e;

  typedef struct packed {
    logic [CountW-1:0] value;
    logic              wrap;
  } step_t;

  // One count step. Up: max_v -> 0 wraps; down: 0 -> max_v wraps.
  // The >= on the up path keeps an out-of-range value from running away.
  function automatic step_t count_step(input logic [CountW-1:0] cur,
                                       input logic              down,
                                       input logic [CountW-1:0] max_v);
    step_t s;
    s.value = cur;
    s.wrap  = 1'b0;
    if (!down) begin
      if (cur >= max_v) begin
        s.value = '0;
        s.wrap  = 1'b1;
      end else begin
        s.value = cur + CountW'(1);
      end
    end else begin
      if (cur == '0) begin
        s.value = max_v;
        s.wrap  = 1'b1;
      end else if (cur > max_v) begin
        s.value = max_v;
      end else begin
        s.value = cur - CountW'(1);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/stopwatch_tick.sv
// Count-step tick generator.
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   i_en   : count enable; when low the divider is held at 0
//   o_tick : high for the single cycle in which the divider holds TICK_DIV-1
// Holding the divider at 0 while disabled makes the first tick land exactly
// TICK_DIV cycles after enable rises.
module stopwatch_tick #(
  parameter int unsigned TICK_DIV = 10_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned    CntW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!i_en) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_tick = i_en && (cnt_q == CntLast);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: run/stop/clear FSM plus the bounded up/down count.
//   clk        : system clock (100 MHz)
//   reset      : asynchronous active-low reset
//   i_run_stop : single-cycle pulse, toggles STOP <-> RUN
//   i_clear    : single-cycle pulse, forces one CLEAR cycle and zeroes count
//   i_mode     : count direction, 0 = up, 1 = down (sampled at each tick)
//   count_data : registered count, 0..COUNT_MAX
//   o_run      : registered, high while in RUN
//   o_wrap     : registered one-cycle pulse, coincident with the wrapped value
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 10_000_000,
  parameter int unsigned COUNT_MAX = 999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_run_stop,
  input  logic              i_clear,
  input  logic              i_mode,
  output logic [CountW-1:0] count_data,
  output logic              o_run,
  output logic              o_wrap
);

  localparam logic [CountW-1:0] CountMaxV = CountW'(COUNT_MAX);

  state_e            state_q;
  logic [CountW-1:0] count_q;
  logic              run_q;
  logic              wrap_q;
  logic              tick;
  logic              tick_en;
  step_t             step;

  assign tick_en = (state_q == StRun);

  stopwatch_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk    (clk),
    .reset  (reset),
    .i_en   (tick_en),
    .o_tick (tick)
  );

  assign step = count_step(count_q, i_mode, CountMaxV);

  // Clear dominates everything, including a same-cycle run/stop or tick.
  // A run/stop coinciding with a tick still lets that step land, because the
  // count update and the state change share the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StStop;
      count_q <= '0;
      run_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (i_clear) begin
        state_q <= StClear;
        count_q <= '0;
        run_q   <= 1'b0;
      end else begin
        if ((state_q == StRun) && tick) begin
          count_q <= step.value;
          wrap_q  <= step.wrap;
        end
        case (state_q)
          StStop: begin
            if (i_run_stop) begin
              state_q <= StRun;
              run_q   <= 1'b1;
            end
          end
          StRun: begin
            if (i_run_stop) begin
              state_q <= StStop;
              run_q   <= 1'b0;
            end
          end
          StClear: begin
            state_q <= StStop;
            count_q <= '0;
            run_q   <= 1'b0;
          end
          default: begin
            state_q <= StStop;
            count_q <= '0;
            run_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign count_data = count_q;
  assign o_run      = run_q;
  assign o_wrap     = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with TICK_DIV=4. A second instance with
// COUNT_MAX=5 covers the up-wrap sequence. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_stopwatch_ctrl;
  import stopwatch_ctrl_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              run_stop, clear, mode;
  logic [CountW-1:0] count;
  logic              run, wrap;
  logic              run_stop5, clear5, mode5;
  logic [CountW-1:0] count5;
  logic              run5, wrap5;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(
    .TICK_DIV  (4),
    .COUNT_MAX (999)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .i_run_stop (run_stop),
    .i_clear    (clear),
    .i_mode     (mode),
    .count_data (count),
    .o_run      (run),
    .o_wrap     (wrap)
  );

  stopwatch_ctrl #(
    .TICK_DIV  (4),
    .COUNT_MAX (5)
  ) dut5 (
    .clk        (clk),
    .reset      (reset),
    .i_run_stop (run_stop5),
    .i_clear    (clear5),
    .i_mode     (mode5),
    .count_data (count5),
    .o_run      (run5),
    .o_wrap     (wrap5)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Called on a falling edge; returns on the falling edge after the pulse edge.
  task automatic pulse_rs();
    run_stop = 1'b1;
    @(negedge clk);
    run_stop = 1'b0;
  endtask

  int wraps;

  initial begin
    reset     = 1'b0;
    run_stop  = 1'b0;
    clear     = 1'b0;
    mode      = 1'b0;
    run_stop5 = 1'b0;
    clear5    = 1'b0;
    mode5     = 1'b0;

    // Reset state, before any clock edge.
    #3;
    check("rst_count", count, 0);
    check("rst_run", run, 0);
    check("rst_wrap", wrap, 0);
    check("rst_state", dut.state_q, StStop);
    check("rst_tickcnt", dut.u_tick.cnt_q, 0);
    @(negedge clk);
    reset = 1'b1;

    // Idle with no pulses.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_count", count, 0);
      check("idle_run", run, 0);
    end

    // Up count: first step TICK_DIV cycles after RUN entry.
    cycles(9);
    pulse_rs();
    check("entry_run", run, 1);
    check("entry_count", count, 0);
    cycles(3);
    check("pre_step", count, 0);
    cycles(1);
    check("up_step1", count, 1);
    check("up_nowrap", wrap, 0);
    cycles(4);
    check("up_step2", count, 2);
    cycles(4);
    check("up_step3", count, 3);

    // Stop holds the count.
    pulse_rs();
    check("stop_run", run, 0);
    check("stop_count", count, 3);
    cycles(20);
    check("stop_hold", count, 3);

    // Run/stop on a tick cycle: the step completes, then STOP.
    pulse_rs();
    check("rerun_run", run, 1);
    cycles(3);
    pulse_rs();
    check("rs_tick_count", count, 4);
    check("rs_tick_run", run, 0);
    cycles(8);
    check("rs_tick_hold", count, 4);

    // Mid-run mode change takes effect at the next tick.
    pulse_rs();
    cycles(4);
    check("mode_up5", count, 5);
    mode = 1'b1;
    cycles(4);
    check("mode_down4", count, 4);
    mode = 1'b0;
    cycles(12);
    check("count7", count, 7);

    // Clear and run/stop together in RUN: clear wins.
    clear    = 1'b1;
    run_stop = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    run_stop = 1'b0;
    check("clr_state", dut.state_q, StClear);
    check("clr_count", count, 0);
    check("clr_run", run, 0);
    check("clr_wrap", wrap, 0);
    cycles(1);
    check("clr_to_stop", dut.state_q, StStop);
    check("clr_stop_run", run, 0);
    cycles(5);
    check("clr_hold", count, 0);
    pulse_rs();
    cycles(4);
    check("restart1", count, 1);

    // Clear on a tick cycle overrides the step.
    cycles(3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clr_tick_count", count, 0);
    check("clr_tick_wrap", wrap, 0);
    check("clr_tick_state", dut.state_q, StClear);
    cycles(1);
    check("clr_tick_stop", dut.state_q, StStop);

    // Down from 0 wraps to COUNT_MAX.
    mode = 1'b1;
    pulse_rs();
    cycles(4);
    check("down_wrapval", count, 999);
    check("down_wrap", wrap, 1);
    cycles(1);
    check("down_wrap_end", wrap, 0);
    cycles(3);
    check("down_998", count, 998);
    pulse_rs();
    check("down_stop", count, 998);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    cycles(1);

    // Reset mid-run aborts without a clock edge.
    mode = 1'b0;
    pulse_rs();
    cycles(48);
    check("run_to12", count, 12);
    check("run_to12_run", run, 1);
    #2;
    reset = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_run", run, 0);
    check("async_wrap", wrap, 0);
    check("async_tickcnt", dut.u_tick.cnt_q, 0);
    @(negedge clk);
    reset = 1'b1;
    cycles(10);
    check("post_rst_count", count, 0);
    check("post_rst_run", run, 0);
    check("post_rst_state", dut.state_q, StStop);

    // COUNT_MAX=5 up-wrap sequence, one wrap pulse only.
    wraps = 0;
    run_stop5 = 1'b1;
    @(negedge clk);
    run_stop5 = 1'b0;
    check("m5_run", run5, 1);
    for (int k = 1; k <= 6; k++) begin
      for (int c = 0; c < 4; c++) begin
        @(negedge clk);
        if (wrap5) wraps++;
      end
      check("m5_seq", count5, k % 6);
      check("m5_wrap_at", wrap5, (k == 6) ? 1 : 0);
    end
    check("m5_wrap_count", wraps, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 10_000_000, sets clk cycles per count step (10 Hz at 100 MHz); legal range 2..2^24.
REQ-002 Parameter COUNT_MAX, default 999, sets the highest count value; legal range 1..999.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  system clock, 100 MHz.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_run_stop  input  1  single-cycle, already-debounced pulse that toggles run/stop.
REQ-007 i_clear  input  1  single-cycle, already-debounced pulse that zeroes the count.
REQ-008 i_mode  input  1  count direction: 0 = up, 1 = down.
REQ-009 count_data  output  11  registered count, feeds the display controller's count input; range 0..COUNT_MAX; bit 10 always 0.
REQ-010 o_run  output  1  high while the state is RUN.
REQ-011 o_wrap  output  1  one-cycle pulse when the count wraps.

Function
REQ-012 The FSM SHALL have three states: STOP, RUN and CLEAR.
REQ-013 STOP + i_run_stop -> RUN.
REQ-014 RUN + i_run_stop -> STOP.
REQ-015 Any state + i_clear -> CLEAR.
REQ-016 CLEAR SHALL last exactly one cycle, then go to STOP.
REQ-017 If i_clear and i_run_stop are high in the same cycle, i_clear SHALL win and i_run_stop SHALL be ignored.
REQ-018 Tick counter: counts 0..TICK_DIV-1 only in RUN and asserts tick on the cycle it holds TICK_DIV-1, then wraps to 0.
REQ-019 The tick counter SHALL be held at 0 in STOP and CLEAR, so the first step occurs TICK_DIV cycles after entering RUN.
REQ-020 On a tick in RUN, count_data SHALL update on the next clk edge (1-cycle latency from tick).
REQ-021 Up mode: count_data = count_data + 1; if count_data == COUNT_MAX it SHALL become 0 and o_wrap SHALL pulse.
REQ-022 Down mode: count_data = count_data - 1; if count_data == 0 it SHALL become COUNT_MAX and o_wrap SHALL pulse.
REQ-023 count_data SHALL never exceed COUNT_MAX; arithmetic SHALL be unsigned 11-bit with no intermediate overflow.
REQ-024 i_mode SHALL be sampled at each tick; a mid-run change SHALL take effect at the next tick with no count glitch.
REQ-025 In CLEAR, count_data SHALL become 0 and o_wrap SHALL stay 0.
REQ-026 A clear arriving in the same cycle as a tick SHALL override the step.
REQ-027 STOP SHALL hold count_data indefinitely.
REQ-028 A run/stop pulse arriving in the same cycle as a tick SHALL allow that tick's step to complete, then apply the state change.
REQ-029 o_run SHALL be a registered decode of the state with no combinational path from inputs.

Reset
REQ-030 While reset == 0, state SHALL be STOP, count_data 0, tick counter 0, o_run 0 and o_wrap 0, independent of clk.
REQ-031 Reset asserted mid-RUN SHALL abort immediately.
REQ-032 After reset deasserts, the block SHALL wait in STOP for i_run_stop.

Structure
REQ-033 The state encoding (STOP=2'd0, RUN=2'd1, CLEAR=2'd2) and the count width constant (11) SHALL live in the shared display package.
REQ-034 The tick generator SHALL be a separate sub-module, stopwatch_tick, with ports clk, reset, i_en, o_tick and parameter TICK_DIV.
REQ-035 The FSM and the count register SHALL be in stopwatch_ctrl.

Verification (TICK_DIV=4, COUNT_MAX=999 unless noted)
REQ-036 Reset low, then high, no pulses -> count_data 0 and o_run 0 for 100 cycles.
REQ-037 i_run_stop pulse at cycle 10, mode up -> o_run 1 from cycle 11; count_data 1,2,3 at 4-cycle intervals, first step 4 cycles after RUN entry.
REQ-038 Preload near COUNT_MAX with COUNT_MAX=5, mode up, run 6 ticks -> sequence 1,2,3,4,5,0; o_wrap pulses exactly once, on the 5->0 step.
REQ-039 Mode down from 0, run -> count_data 999, then 998; o_wrap pulses on 0->999.
REQ-040 i_clear and i_run_stop together while in RUN at count 7 -> one cycle in CLEAR, count_data 0, then STOP with o_run 0; a later run pulse restarts from 0.
REQ-041 Reset low mid-RUN at count 12 -> count_data 0 and o_run 0 immediately, with no clk edge needed.
